// File: rtl/seq_pattern_generator.sv
// Serial pattern transmitter: sends PATTERN MSB-first, one bit per rising edge of
// the debounced step input, in single-shot or continuous-repeat mode.
//
// Handshake: V=1 marks X and Q as a valid pattern bit. done is a one-cycle pulse
// that coincides with count already holding its incremented value.
module seq_pattern_generator #(
  parameter logic [7:0]  PATTERN = 8'b0001_0110,
  parameter int unsigned LEN     = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic       start,
  input  logic       stop,
  input  logic       M,
  output logic       X,
  output logic       V,
  output logic [2:0] Q,
  output logic       done,
  output logic [7:0] count,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] LAST = 3'(LEN - 1);

  state_t     state, state_nxt;
  logic       step_d;
  logic       step_edge;
  logic       x_nxt, v_nxt, done_nxt;
  logic [2:0] q_nxt, q_inc;
  logic [7:0] count_nxt;

  assign step_edge = step & ~step_d;
  assign q_inc     = Q + 3'd1;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      step_d <= 1'b0;
      X      <= 1'b0;
      V      <= 1'b0;
      Q      <= 3'd0;
      done   <= 1'b0;
      count  <= 8'd0;
    end else begin
      state  <= state_nxt;
      step_d <= step;
      X      <= x_nxt;
      V      <= v_nxt;
      Q      <= q_nxt;
      done   <= done_nxt;
      count  <= count_nxt;
    end
  end

  // stop outranks everything; M is only consulted on the final-bit step edge
  always_comb begin
    state_nxt = state;
    x_nxt     = X;
    v_nxt     = V;
    q_nxt     = Q;
    done_nxt  = 1'b0;
    count_nxt = count;
    if (stop) begin
      state_nxt = IDLE;
      x_nxt     = 1'b0;
      v_nxt     = 1'b0;
      q_nxt     = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          x_nxt = 1'b0;
          v_nxt = 1'b0;
          q_nxt = 3'd0;
          if (start) begin
            state_nxt = SEND;
            x_nxt     = PATTERN[LAST];
            v_nxt     = 1'b1;
          end
        end
        SEND: begin
          if (step_edge) begin
            if (Q == LAST) begin
              done_nxt  = 1'b1;
              count_nxt = count + 8'd1;
              q_nxt     = 3'd0;
              if (M) begin
                x_nxt = PATTERN[LAST];
                v_nxt = 1'b1;
              end else begin
                state_nxt = DONE;
                x_nxt     = 1'b0;
                v_nxt     = 1'b0;
              end
            end else begin
              q_nxt = q_inc;
              x_nxt = PATTERN[LAST - q_inc];
            end
          end
        end
        DONE: begin
          state_nxt = IDLE;
          x_nxt     = 1'b0;
          v_nxt     = 1'b0;
          q_nxt     = 3'd0;
        end
        default: begin
          state_nxt = IDLE;
          x_nxt     = 1'b0;
          v_nxt     = 1'b0;
          q_nxt     = 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_generator.sv
// Bench for seq_pattern_generator: stimulus tasks push expected output events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_seq_pattern_generator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       step = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       M = 1'b0;
  logic       X, V, done;
  logic [2:0] Q;
  logic [7:0] count;
  logic [1:0] state_dbg;

  // expected event record: {done, count[7:0], X, V, Q[2:0]}
  logic [13:0] exp_q[$];
  logic [13:0] e;
  logic        ev;
  logic        v_prev = 1'b0;
  logic [2:0]  q_prev = 3'd0;

  int n_cmp = 0;
  int n_err = 0;

  // reference pattern and model state
  logic [5:0] pat = 6'b010110;
  logic [2:0] mq = 3'd0;
  logic [7:0] mcnt = 8'd0;

  seq_pattern_generator dut (
    .clk(clk), .reset(rst_n), .step(step), .start(start), .stop(stop), .M(M),
    .X(X), .V(V), .Q(Q), .done(done), .count(count), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // monitor: an output event is a done pulse, V rising, or Q moving while valid
  always @(negedge clk) begin
    if (rst_n) begin
      ev = done | (V & (!v_prev | (Q != q_prev)));
      if (ev) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event: got done=%0b count=%0d X=%0b V=%0b Q=%0d, expected no event",
                   done, count, X, V, Q);
        end else begin
          e = exp_q.pop_front();
          if ({done, count, X, V, Q} !== e) begin
            n_err++;
            $display("FAIL event: got done=%0b count=%0d X=%0b V=%0b Q=%0d, expected done=%0b count=%0d X=%0b V=%0b Q=%0d",
                     done, count, X, V, Q, e[13], e[12:5], e[4], e[3], e[2:0]);
          end
        end
      end
    end
    v_prev = V;
    q_prev = Q;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string name, input logic [7:0] exp_cnt);
    check({name, "_outs"}, {11'd0, X, V, Q}, 16'd0);
    check({name, "_done"}, {15'd0, done}, 16'd0);
    check({name, "_count"}, {8'd0, count}, {8'd0, exp_cnt});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_start();
    mq = 3'd0;
    exp_q.push_back({1'b0, mcnt, pat[5], 1'b1, 3'd0});
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  // one rising step edge; the model decides what the DUT must present next
  task automatic do_step();
    if (mq < 3'd5) begin
      mq = mq + 3'd1;
      exp_q.push_back({1'b0, mcnt, pat[3'd5 - mq], 1'b1, mq});
    end else begin
      mcnt = mcnt + 8'd1;
      mq   = 3'd0;
      if (M) exp_q.push_back({1'b1, mcnt, pat[5], 1'b1, 3'd0});
      else   exp_q.push_back({1'b1, mcnt, 1'b0, 1'b0, 3'd0});
    end
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    cyc(2);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    cyc(1);
  endtask

  task automatic wait_drain(input string name);
    int budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      cyc(1);
      budget--;
    end
    check({name, "_drain"}, 16'(exp_q.size()), 16'd0);
    exp_q.delete();
  endtask

  initial begin
    // reset state
    #3;
    check_idle("reset", 8'd0);
    check("reset_state", {14'd0, state_dbg}, 16'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    check_idle("post_reset", 8'd0);

    // single-shot: M changes mid-pattern are ignored until the final edge
    M = 1'b1;
    do_start();
    for (int i = 0; i < 5; i++) do_step();
    M = 1'b0;
    do_step();
    cyc(3);
    wait_drain("single");
    check_idle("single_end", 8'd1);

    // start ignored while in DONE, then back to IDLE
    do_start();
    for (int i = 0; i < 5; i++) do_step();
    step = 1'b1;
    start = 1'b1;
    mcnt = mcnt + 8'd1;
    exp_q.push_back({1'b1, mcnt, 1'b0, 1'b0, 3'd0});
    cyc(1);
    step = 1'b0;
    cyc(1);
    start = 1'b0;
    cyc(3);
    wait_drain("start_in_done");
    check_idle("start_in_done_end", 8'd2);

    // continuous: two full patterns, Q wraps
    M = 1'b1;
    do_start();
    for (int i = 0; i < 12; i++) do_step();
    wait_drain("cont");
    check("cont_v", {15'd0, V}, 16'd1);
    check("cont_count", {8'd0, count}, 16'd4);
    do_stop();
    check_idle("cont_stop", 8'd4);

    // abort: stop coincident with a step edge at Q=3
    do_start();
    for (int i = 0; i < 3; i++) do_step();
    wait_drain("abort_pre");
    check("abort_q3", {13'd0, Q}, 16'd3);
    step = 1'b1;
    stop = 1'b1;
    cyc(1);
    step = 1'b0;
    stop = 1'b0;
    check_idle("abort", 8'd4);
    cyc(3);
    wait_drain("abort");

    // held step plus start pulses during SEND: exactly one advance
    do_start();
    mq = 3'd1;
    exp_q.push_back({1'b0, mcnt, pat[4], 1'b1, 3'd1});
    step = 1'b1;
    for (int i = 0; i < 20; i++) begin
      start = i[0];
      cyc(1);
    end
    step = 1'b0;
    start = 1'b0;
    cyc(2);
    wait_drain("held");
    check("held_q", {13'd0, Q}, 16'd1);
    do_stop();
    check_idle("held_stop", 8'd4);

    // async reset mid-SEND at Q=4
    do_start();
    for (int i = 0; i < 4; i++) do_step();
    wait_drain("areset_pre");
    check("areset_q4", {13'd0, Q}, 16'd4);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle("areset", 8'd0);
    mcnt = 8'd0;
    mq   = 3'd0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    check_idle("areset_after", 8'd0);

    // count wrap: 256 continuous patterns
    M = 1'b1;
    do_start();
    for (int p = 0; p < 256; p++)
      for (int b = 0; b < 6; b++) do_step();
    wait_drain("wrap");
    check("wrap_count", {8'd0, count}, 16'd0);
    do_stop();
    check_idle("wrap_stop", 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_pattern_generator.md
SEQ_PATTERN_GENERATOR -- requirements
Module: seq_pattern_generator

Interface
REQ-001 SHALL provide parameter PATTERN, default 6'b010110, the serial pattern to transmit, MSB first.
REQ-002 SHALL provide parameter LEN, default 6, the pattern length in bits (legal range 2..8).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port step  input  1  debounced step level; a rising edge (sampled 0 then 1) advances one bit.
REQ-006 SHALL have port start  input  1  level, sampled each cycle; launches transmission from IDLE.
REQ-007 SHALL have port stop  input  1  level, sampled each cycle; synchronous abort to IDLE.
REQ-008 SHALL have port M  input  1  mode: 0 = single-shot, 1 = continuous repeat.
REQ-009 SHALL have port X  output  1  serial pattern bit, registered.
REQ-010 SHALL have port V  output  1  X valid, registered.
REQ-011 SHALL have port Q  output  3  current bit index within the pattern, registered.
REQ-012 SHALL have port done  output  1  one-cycle pulse at each pattern completion.
REQ-013 SHALL have port count  output  8  number of completed patterns since reset.

Function
REQ-014 SHALL implement states IDLE, SEND, DONE; state encoding is free.
REQ-015 SHALL register step into step_d each cycle; step_edge = step & ~step_d.
REQ-016 IDLE: X=0, V=0, Q=0; start=1 SHALL move to SEND next cycle with Q=0, X=PATTERN[LEN-1], V=1.
REQ-017 SEND, step_edge with Q<LEN-1: SHALL set Q=Q+1 and X=PATTERN[LEN-2-Q] next cycle, V held 1.
REQ-018 SEND, step_edge with Q=LEN-1 and M=1: SHALL wrap Q to 0, set X=PATTERN[LEN-1], assert done for 1 cycle, increment count; V stays 1.
REQ-019 SEND, step_edge with Q=LEN-1 and M=0: SHALL go to DONE with X=0, V=0, done=1 for 1 cycle, count incremented.
REQ-020 DONE SHALL return to IDLE unconditionally on the next cycle; start is ignored in DONE.
REQ-021 SEND without step_edge: X, V, Q SHALL hold.
REQ-022 start SHALL be ignored in SEND and DONE.
REQ-023 M SHALL be sampled only at the cycle of the final-bit step_edge; changes mid-pattern have no effect until then.
REQ-024 stop=1 in any state SHALL force IDLE next cycle (X=0, V=0, Q=0, done=0), with priority over step_edge and start; count unchanged.
REQ-025 count SHALL wrap 255 -> 0 without saturation.
REQ-026 step held high SHALL produce exactly one advance; step edges in IDLE or DONE SHALL be ignored, but step_d tracks in all states.
REQ-027 done SHALL never be asserted for more than one consecutive cycle.

Reset
REQ-028 reset=0 SHALL immediately force state=IDLE, X=0, V=0, Q=0, done=0, count=0, step_d=0, independent of clk.
REQ-029 On reset deassertion, operation SHALL resume at the first rising clk edge; reset mid-SEND discards the partial pattern without a done pulse.

Verification
REQ-030 Single-shot: M=0, start pulse, 6 step edges -> X sequence 0,1,0,1,1,0 with V=1 and Q=0..5; on the 6th edge done=1 for one cycle, V=0, count=1, then IDLE.
REQ-031 Continuous: M=1, start, 12 step edges -> X repeats 010110 twice, done pulses on edges 6 and 12, count=2, V stays 1, Q wraps 5->0.
REQ-032 Abort: M=1, start, 3 step edges (Q=3), then stop coincident with a step edge -> next cycle IDLE, X=0, V=0, Q=0, done=0, count unchanged.
REQ-033 Held step: step held high 20 cycles in SEND -> exactly one advance (Q 0->1); start pulses during SEND have no effect.
REQ-034 Async reset: assert reset=0 mid-cycle while in SEND at Q=4 -> outputs clear before next clk edge, count=0, no done pulse.
REQ-035 Count wrap: M=1, 256 complete patterns -> count reads 0 after the 256th done pulse.
